button_debounce_sync: RTL and testbench

- Front-end conditioning stage for a raw, asynchronous push-button or switch input on the iCE40 board.
- Synchronises the input into the clk domain and filters out contact bounce. It produces a clean level plus single-cycle rise/fall strobes.
- btn_level drives the data input of the downstream rising-edge D flip-flop stage directly.
- Also counts rejected bounce events for board bring-up diagnostics.

---
 rtl/button_debounce_sync.sv | 160 ++++++++++++++++
 tb/tb_button_debounce_sync.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_sync.sv
// Push-button conditioning front end: two-flop synchroniser, bounce filter
// with a stability timer, registered level/edge strobes and a saturating
// counter of rejected (bounced) transitions for bring-up diagnostics.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE_LOW  | level is 0, waiting for the synchronised input to go 1
// WAIT_HIGH | input went 1, timing how long it stays 1 before accepting
// IDLE_HIGH | level is 1, waiting for the synchronised input to go 0
// WAIT_LOW  | input went 0, timing how long it stays 0 before accepting
module button_debounce_sync #(
  parameter int unsigned STABLE_COUNT = 4,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned BOUNCE_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_in,
  output logic                btn_level,
  output logic                btn_rise,
  output logic                btn_fall,
  output logic [BOUNCE_W-1:0] bounce_count
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // The stability timer is a down-counter: loaded with STABLE_COUNT-1 on
  // entering a WAIT state and accepting the new value once it reads zero
  // with the input still at the new level. This takes the same number of
  // cycles as counting up from zero to STABLE_COUNT-1.
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD   = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [BOUNCE_W-1:0]  BOUNCE_ONE = BOUNCE_W'(1);
  localparam logic [BOUNCE_W-1:0]  BOUNCE_MAX = '1;

  logic                sync_1_q, sync_1_d;
  logic                sync_2_q, sync_2_d;
  state_t              state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                btn_level_q, btn_level_d;
  logic                btn_rise_q, btn_rise_d;
  logic                btn_fall_q, btn_fall_d;
  logic [BOUNCE_W-1:0] bounce_q, bounce_d;
  logic                bounce_hit;

  // Synchroniser chain; only sync_2 is ever looked at by the filter.
  always_comb begin
    sync_1_d = btn_in;
    sync_2_d = sync_1_q;
  end

  // Filter next-state, timer, registered strobes and bounce accounting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    btn_level_d = btn_level_q;
    btn_rise_d  = 1'b0;
    btn_fall_d  = 1'b0;
    bounce_hit  = 1'b0;

    case (state_q)
      IDLE_LOW: begin
        if (sync_2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_LOAD;
        end
      end

      WAIT_HIGH: begin
        if (sync_2_q) begin
          if (cnt_q == '0) begin
            state_d     = IDLE_HIGH;
            btn_level_d = 1'b1;
            btn_rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          state_d    = IDLE_LOW;
          cnt_d      = '0;
          bounce_hit = 1'b1;
        end
      end

      IDLE_HIGH: begin
        if (!sync_2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_LOAD;
        end
      end

      WAIT_LOW: begin
        if (!sync_2_q) begin
          if (cnt_q == '0) begin
            state_d     = IDLE_LOW;
            btn_level_d = 1'b0;
            btn_fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          state_d    = IDLE_HIGH;
          cnt_d      = '0;
          bounce_hit = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE_LOW;
        cnt_d       = '0;
        btn_level_d = 1'b0;
      end
    endcase

    // Saturate rather than wrap so a noisy switch can't look clean again.
    bounce_d = bounce_q;
    if (bounce_hit && (bounce_q != BOUNCE_MAX)) begin
      bounce_d = bounce_q + BOUNCE_ONE;
    end
  end

  // All state, with synchronous active-low reset; a reset in a WAIT state
  // simply drops the pending transition without touching the bounce count
  // beyond clearing it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_1_q    <= 1'b0;
      sync_2_q    <= 1'b0;
      state_q     <= IDLE_LOW;
      cnt_q       <= '0;
      btn_level_q <= 1'b0;
      btn_rise_q  <= 1'b0;
      btn_fall_q  <= 1'b0;
      bounce_q    <= '0;
    end else begin
      sync_1_q    <= sync_1_d;
      sync_2_q    <= sync_2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_level_q <= btn_level_d;
      btn_rise_q  <= btn_rise_d;
      btn_fall_q  <= btn_fall_d;
      bounce_q    <= bounce_d;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    btn_level    = btn_level_q;
    btn_rise     = btn_rise_q;
    btn_fall     = btn_fall_q;
    bounce_count = bounce_q;
  end

endmodule

// File: tb/tb_button_debounce_sync.sv
// Scoreboard bench for button_debounce_sync. Stimulus pushes cycle-stamped
// expected snapshots and expected strobe events; a monitor on the falling
// edge pops and compares them as the DUT reaches those cycles / pulses.
module tb_button_debounce_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_in;
  logic       lvl, rise, fall;
  logic [7:0] bcnt;
  logic       lvl_s, rise_s, fall_s;
  logic [1:0] bcnt_s;

  int edge_cnt = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int   cyc;
    logic lvl;
    logic rise;
    logic fall;
    int   bc;
    int   bcs;
  } snap_t;

  typedef struct {
    int cyc;
    bit is_rise;
  } ev_t;

  snap_t snap_q[$];
  ev_t   ev_q[$];
  snap_t s;
  ev_t   e;

  button_debounce_sync #(.STABLE_COUNT(4), .CNT_WIDTH(16), .BOUNCE_W(8)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(lvl), .btn_rise(rise), .btn_fall(fall), .bounce_count(bcnt)
  );

  button_debounce_sync #(.STABLE_COUNT(4), .CNT_WIDTH(16), .BOUNCE_W(2)) dut_sat (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(lvl_s), .btn_rise(rise_s), .btn_fall(fall_s), .bounce_count(bcnt_s)
  );

  always #10 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", nm, c, act, exp);
    end
  endtask

  task automatic push_snap(input int c, input logic l, input logic r, input logic f,
                           input int bc, input int bcs);
    snap_t t;
    t.cyc = c; t.lvl = l; t.rise = r; t.fall = f; t.bc = bc; t.bcs = bcs;
    snap_q.push_back(t);
  endtask

  task automatic push_ev(input int c, input bit is_rise);
    ev_t t;
    t.cyc = c; t.is_rise = is_rise;
    ev_q.push_back(t);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: compare snapshots due this cycle and any strobe the DUT shows.
  always @(negedge clk) begin
    while (snap_q.size() > 0 && snap_q[0].cyc <= edge_cnt) begin
      s = snap_q.pop_front();
      if (s.cyc < edge_cnt) begin
        check("snapshot_missed", edge_cnt, 32'(s.cyc), 32'(edge_cnt));
      end else begin
        check("btn_level",      edge_cnt, 32'(lvl),    32'(s.lvl));
        check("btn_rise",       edge_cnt, 32'(rise),   32'(s.rise));
        check("btn_fall",       edge_cnt, 32'(fall),   32'(s.fall));
        check("bounce_count",   edge_cnt, 32'(bcnt),   32'(s.bc));
        check("sat_level",      edge_cnt, 32'(lvl_s),  32'(s.lvl));
        check("sat_rise",       edge_cnt, 32'(rise_s), 32'(s.rise));
        check("sat_fall",       edge_cnt, 32'(fall_s), 32'(s.fall));
        check("sat_bounce_cnt", edge_cnt, 32'(bcnt_s), 32'(s.bcs));
      end
    end
    if (rise === 1'b1 || fall === 1'b1) begin
      if (ev_q.size() == 0) begin
        check("unexpected_strobe", edge_cnt, {30'd0, rise, fall}, 32'd0);
      end else begin
        e = ev_q.pop_front();
        check("strobe_cycle", edge_cnt, 32'(edge_cnt), 32'(e.cyc));
        check("strobe_kind",  edge_cnt, 32'(rise),     32'(e.is_rise));
      end
      check("rise_and_fall", edge_cnt, 32'(rise & fall), 32'd0);
    end
  end

  initial begin
    int n;
    // T1: reset held two edges with the button already pressed.
    reset  = 1'b0;
    btn_in = 1'b1;
    push_snap(1, 0, 0, 0, 0, 0);
    push_snap(2, 0, 0, 0, 0, 0);
    tick(2);
    reset = 1'b1;

    // T2: button still held; first sampled at the next edge.
    n = edge_cnt + 1;
    push_snap(n + 5, 0, 0, 0, 0, 0);
    push_ev(n + 6, 1'b1);
    push_snap(n + 6, 1, 1, 0, 0, 0);
    push_snap(n + 7, 1, 0, 0, 0, 0);
    tick(12);

    // T4: clean release.
    btn_in = 1'b0;
    n = edge_cnt + 1;
    push_snap(n + 5, 1, 0, 0, 0, 0);
    push_ev(n + 6, 1'b0);
    push_snap(n + 6, 0, 0, 1, 0, 0);
    push_snap(n + 7, 0, 0, 0, 0, 0);
    tick(10);

    // T3: 1,0,1,0 every two cycles, then settle low -> two aborts.
    n = edge_cnt + 1;
    push_snap(n + 3,  0, 0, 0, 0, 0);
    push_snap(n + 4,  0, 0, 0, 1, 1);
    push_snap(n + 8,  0, 0, 0, 2, 2);
    push_snap(n + 14, 0, 0, 0, 2, 2);
    btn_in = 1'b1; tick(2);
    btn_in = 1'b0; tick(2);
    btn_in = 1'b1; tick(2);
    btn_in = 1'b0; tick(14);

    // Boundary: 4-cycle pulse (one short of acceptance) is a bounce.
    n = edge_cnt + 1;
    push_snap(n + 5,  0, 0, 0, 2, 2);
    push_snap(n + 6,  0, 0, 0, 3, 3);
    push_snap(n + 13, 0, 0, 0, 3, 3);
    btn_in = 1'b1; tick(4);
    btn_in = 1'b0; tick(14);

    // Boundary: 5-cycle pulse is just long enough, then releases cleanly.
    n = edge_cnt + 1;
    push_ev(n + 6, 1'b1);
    push_snap(n + 6,  1, 1, 0, 3, 3);
    push_snap(n + 10, 1, 0, 0, 3, 3);
    push_ev(n + 11, 1'b0);
    push_snap(n + 11, 0, 0, 1, 3, 3);
    btn_in = 1'b1; tick(5);
    btn_in = 1'b0; tick(16);

    // T5: reset clears counts, then five aborted presses saturate BOUNCE_W=2.
    reset = 1'b0;
    push_snap(edge_cnt + 1, 0, 0, 0, 0, 0);
    tick(1);
    reset = 1'b1;
    tick(3);
    for (int k = 1; k <= 5; k++) begin
      n = edge_cnt + 1;
      push_snap(n + 4, 0, 0, 0, k, (k > 3) ? 3 : k);
      btn_in = 1'b1; tick(2);
      btn_in = 1'b0; tick(2);
    end
    push_snap(edge_cnt + 6, 0, 0, 0, 5, 3);
    tick(8);

    // T6: reset while in WAIT_HIGH with two timer steps taken.
    reset = 1'b0; tick(1);
    reset = 1'b1; tick(3);
    btn_in = 1'b1;
    n = edge_cnt + 1;
    push_snap(n + 4, 0, 0, 0, 0, 0);
    tick(5);
    reset  = 1'b0;
    btn_in = 1'b0;
    push_snap(edge_cnt + 1, 0, 0, 0, 0, 0);
    tick(1);
    reset = 1'b1;
    push_snap(edge_cnt + 4, 0, 0, 0, 0, 0);
    tick(5);
    btn_in = 1'b1;
    n = edge_cnt + 1;
    push_snap(n + 5, 0, 0, 0, 0, 0);
    push_ev(n + 6, 1'b1);
    push_snap(n + 6, 1, 1, 0, 0, 0);
    push_snap(n + 7, 1, 0, 0, 0, 0);
    tick(12);

    check("pending_strobes",   edge_cnt, 32'(ev_q.size()),   32'd0);
    check("pending_snapshots", edge_cnt, 32'(snap_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
